morty_wb_arbiter: RTL and testbench
===================================

Name: morty_wb_arbiter

Overview:
- Two-master to one-slave Wishbone (classic, 32-bit) arbiter for the Morty core.
- Shares the single external bus between the instruction-fetch unit (master 0) and the load/store unit (master 1).
- Round-robin grant, held for the whole cycle.
- Bus-timeout watchdog returns an error to the stalled master, so the core never hangs on a dead slave.

Parameters:
TIMEOUT_CYCLES, 255, cycles of s_stb_o without ack/err before the arbiter terminates with error; 0 disables the watchdog.

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
m0_cyc_i / m1_cyc_i  in  1  master cycle request
m0_stb_i / m1_stb_i  in  1  master strobe
m0_we_i / m1_we_i  in  1  master write enable
m0_sel_i / m1_sel_i  in  4  master byte selects
m0_adr_i / m1_adr_i  in  32  master address
m0_dat_i / m1_dat_i  in  32  master write data
m0_dat_o / m1_dat_o  out  32  read data to master
m0_ack_o / m1_ack_o  out  1  ack to master
m0_err_o / m1_err_o  out  1  error to master
s_cyc_o, s_stb_o, s_we_o  out  1  slave cycle, strobe, write enable
s_sel_o  out  4  slave byte selects
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_ack_i, s_err_i  in  1  slave ack, error
grant_o  out  2  one-hot current grant; 00 = idle

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_ni).
- Reset: state=IDLE, last_grant=M1 (so M0 wins first tie), timeout counter=0, grant_o=00.
  - All slave outputs 0; all master ack/err 0.
  - Takes effect immediately, including mid-transaction.
- States: IDLE, GNT0, GNT1. State register updates on clk_i only.
- IDLE -> GNTx on the edge after mX_cyc_i=1. Arbitration latency is 1 cycle.
  - Both request: grant the master that is not last_grant.
- GNTx held while mX_cyc_i=1, regardless of the other master.
- GNTx with mX_cyc_i=0 at the edge: last_grant<=x.
  - Other master requesting: go directly to its GNT state (no idle bubble).
  - Otherwise: go to IDLE.
- Slave mux, combinational from state:
  - s_cyc/stb/we/sel/adr/dat = granted master's inputs.
  - IDLE forces s_cyc_o=s_stb_o=0; sel, adr and dat are 0.
- Return path, combinational:
  - mX_ack_o = s_ack_i & GNTx.
  - mX_err_o = (s_err_i | timeout_hit) & GNTx.
  - mX_dat_o = s_dat_i when GNTx, else 0.
  - Non-granted master always sees ack=err=0.
- Watchdog:
  - Counter width $clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle with s_stb_o=1 & ~s_ack_i & ~s_err_i.
  - Clears on ack, err, grant change, or timeout_hit.
  - timeout_hit = (counter==TIMEOUT_CYCLES) & s_stb_o & TIMEOUT_CYCLES!=0.
  - In the timeout_hit cycle the arbiter forces s_cyc_o=s_stb_o=0 and pulses mX_err_o for exactly one cycle.
- Simultaneous s_ack_i and s_err_i: both forwarded unchanged; the master resolves them.
- A master dropping cyc with no ack: the grant is released. No error is generated.

Test Plan:
- Single M1 store:
  - Stimulus: m1_cyc=stb=1, we=1, sel=0011, adr=0x100, dat=0xBEEF, from IDLE; slave acks 2 cycles later.
  - Required: grant_o=10 one cycle later; s_adr_o=0x100, s_sel_o=0011; m1_ack_o pulses; m0_ack_o stays 0.
- Simultaneous request after reset:
  - Stimulus: m0 and m1 request in the same cycle.
  - Required: M0 granted first. When m0_cyc drops, grant_o goes 01 -> 10 on the next edge with no IDLE cycle.
- Fairness:
  - Stimulus: M0 and M1 both issue repeated back-to-back cycles.
  - Required: grants alternate 01,10,01,10. Neither master is granted twice in a row while the other waits.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; M0 read; slave never acks.
  - Required: s_stb_o high for 4 cycles; the 5th cycle has s_stb_o=0 and m0_err_o=1 for exactly one cycle; the counter then returns to 0.
- Slave error passthrough:
  - Stimulus: M1 load; s_err_i=1 in the first cycle.
  - Required: m1_err_o=1 in the same cycle; m1_ack_o=0; the counter clears.
- Reset mid-operation:
  - Stimulus: rst_ni low during GNT1 with s_stb_o=1, asserted asynchronously between clock edges.
  - Required: s_cyc_o=s_stb_o=0 and grant_o=00 immediately. After release, a simultaneous request grants M0.

Source files
------------

// File: rtl/morty_wb_arbiter.sv
// Two-master to one-slave classic Wishbone arbiter for the Morty core (M0 = fetch, M1 = load/store).
// Round-robin grant held for a whole cycle, plus a bus-timeout watchdog that errors out a stalled master.
module morty_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  // A zero timeout still needs a legal one-bit counter; the watchdog is simply never armed.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;   // 0 = M0 was last owner, 1 = M1
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt0, gnt1;
  logic               stb_raw;
  logic               timeout_hit;

  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign grant_o = {gnt1, gnt0};

  // Hit is judged on the master's own strobe, since s_stb_o itself is suppressed in that cycle.
  assign stb_raw     = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) & stb_raw & (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'd0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    if (gnt0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (gnt1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
    if (timeout_hit) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  assign m0_ack_o = s_ack_i & gnt0;
  assign m1_ack_o = s_ack_i & gnt1;
  assign m0_err_o = (s_err_i | timeout_hit) & gnt0;
  assign m1_err_o = (s_err_i | timeout_hit) & gnt1;
  assign m0_dat_o = gnt0 ? s_dat_i : 32'd0;
  assign m1_dat_o = gnt1 ? s_dat_i : 32'd0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s_ack_i || s_err_i || timeout_hit || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (s_stb_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_morty_wb_arbiter.sv
// Directed plus randomized bench for morty_wb_arbiter, checked against a
// transaction-level ownership model kept in the bench.
module tb_morty_wb_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat;
  logic        s_ack, s_err;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  // Model: owner 0 = nobody, 1 = M0, 2 = M1; last = previous owner; wd = stalled strobe cycles.
  int own, last, wd;
  logic        e_cyc, e_stb, e_we, e_hit;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_dat;
  logic [1:0]  e_grant;

  always #5 clk = ~clk;

  morty_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; last = 2; wd = 0;
  endtask

  task automatic model_eval();
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0; e_grant = 2'b00;
    if (own == 1) begin
      e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we; e_sel = m0_sel; e_adr = m0_adr; e_dat = m0_dat;
      e_grant = 2'b01;
    end else if (own == 2) begin
      e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we; e_sel = m1_sel; e_adr = m1_adr; e_dat = m1_dat;
      e_grant = 2'b10;
    end
    e_hit = (TO != 0) && (own != 0) && (wd == TO) && e_stb;
    if (e_hit) begin
      e_cyc = 0; e_stb = 0;
    end
  endtask

  task automatic model_step();
    int nxt;
    model_eval();
    nxt = own;
    if (own == 0) begin
      if (m0_cyc && m1_cyc) nxt = (last == 2) ? 1 : 2;
      else if (m0_cyc)      nxt = 1;
      else if (m1_cyc)      nxt = 2;
    end else if (own == 1 && !m0_cyc) begin
      last = 1; nxt = m1_cyc ? 2 : 0;
    end else if (own == 2 && !m1_cyc) begin
      last = 2; nxt = m0_cyc ? 1 : 0;
    end
    if (s_ack || s_err || e_hit || nxt != own) wd = 0;
    else if (e_stb) wd++;
    own = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic check_all();
    #1;
    model_eval();
    chk("grant", {30'd0, grant_o}, {30'd0, e_grant});
    chk("s_cyc", {31'd0, s_cyc_o}, {31'd0, e_cyc});
    chk("s_stb", {31'd0, s_stb_o}, {31'd0, e_stb});
    chk("s_we",  {31'd0, s_we_o},  {31'd0, e_we});
    chk("s_sel", {28'd0, s_sel_o}, {28'd0, e_sel});
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", s_dat_o, e_dat);
    chk("m0_ack", {31'd0, m0_ack_o}, {31'd0, s_ack & (own == 1)});
    chk("m1_ack", {31'd0, m1_ack_o}, {31'd0, s_ack & (own == 2)});
    chk("m0_err", {31'd0, m0_err_o}, {31'd0, (s_err | e_hit) & (own == 1)});
    chk("m1_err", {31'd0, m1_err_o}, {31'd0, (s_err | e_hit) & (own == 2)});
    chk("m0_dat", m0_dat_o, (own == 1) ? s_dat : 32'd0);
    chk("m1_dat", m1_dat_o, (own == 2) ? s_dat : 32'd0);
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dat = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dat = 0;
    s_ack = 0; s_err = 0; s_dat = 32'h1234_5678;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    tick();
    check_all();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    // Reset state
    tick();
    check_all();
    chk("reset_grant", {30'd0, grant_o}, 32'd0);
    rst_n = 1;

    // Single M1 store, slave acks two cycles after grant
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011; m1_adr = 32'h100; m1_dat = 32'hBEEF;
    check_all();
    chk("store_grant_latency", {30'd0, grant_o}, 32'd0);
    tick(); check_all();
    chk("store_grant", {30'd0, grant_o}, 32'b10);
    chk("store_adr", s_adr_o, 32'h100);
    chk("store_sel", {28'd0, s_sel_o}, 32'b0011);
    tick(); check_all();
    tick(); s_ack = 1; check_all();
    chk("store_m1_ack", {31'd0, m1_ack_o}, 32'd1);
    chk("store_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    tick(); idle_inputs(); check_all();
    tick(); check_all();

    // Simultaneous request after reset: M0 first, then M1 with no idle bubble
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0; m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
    check_all();
    tick(); check_all();
    chk("tie_first", {30'd0, grant_o}, 32'b01);
    m0_cyc = 0; m0_stb = 0;
    check_all();
    tick(); check_all();
    chk("tie_handover", {30'd0, grant_o}, 32'b10);

    // Fairness: both keep requesting; owner drops cyc for one cycle after each ack
    begin
      int exp_own;
      exp_own = 2;
      m0_cyc = 1; m0_stb = 1;
      for (int i = 0; i < 6; i++) begin
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        check_all();
        chk("fair_grant", {30'd0, grant_o}, (exp_own == 1) ? 32'b01 : 32'b10);
        tick();
        s_ack = 0;
        if (exp_own == 1) begin m0_cyc = 0; m0_stb = 0; end
        else begin m1_cyc = 0; m1_stb = 0; end
        check_all();
        tick();
        exp_own = (exp_own == 1) ? 2 : 1;
      end
    end

    // Timeout: M0 read with a dead slave
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hDEAD0;
    check_all();
    tick();
    for (int c = 0; c < TO; c++) begin
      check_all();
      chk("to_stb_high", {31'd0, s_stb_o}, 32'd1);
      chk("to_no_err", {31'd0, m0_err_o}, 32'd0);
      tick();
    end
    check_all();
    chk("to_stb_low", {31'd0, s_stb_o}, 32'd0);
    chk("to_err", {31'd0, m0_err_o}, 32'd1);
    tick(); check_all();
    chk("to_err_once", {31'd0, m0_err_o}, 32'd0);
    chk("to_restart", {31'd0, s_stb_o}, 32'd1);
    m0_cyc = 0; m0_stb = 0;
    check_all();
    tick(); check_all();

    // Slave error passthrough on first cycle of an M1 load
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    check_all();
    tick(); s_err = 1; check_all();
    chk("serr_m1_err", {31'd0, m1_err_o}, 32'd1);
    chk("serr_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    tick(); s_err = 0;
    for (int c = 0; c < TO; c++) begin
      check_all();
      chk("serr_cnt_clear", {31'd0, s_stb_o}, 32'd1);
      tick();
    end
    check_all();
    chk("serr_then_to", {31'd0, m1_err_o}, 32'd1);
    tick(); check_all();

    // Asynchronous reset mid-transaction in GNT1
    chk("mid_pre_grant", {30'd0, grant_o}, 32'b10);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'd0, s_stb_o}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant_o}, 32'd0);
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    rst_n = 1;
    tick(); check_all();
    chk("post_rst_tie", {30'd0, grant_o}, 32'b01);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      tick();
      m0_cyc = m0_cyc ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      m1_cyc = m1_cyc ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      m0_stb = m0_cyc & ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc & ($urandom_range(0, 3) != 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat = $urandom; m1_dat = $urandom;
      s_dat = $urandom;
      s_ack = ($urandom_range(0, 4) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      check_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
